// File: rtl/io_port_responder_pkg.sv
// Shared types and default sizes for the I/O port responder.
// State encodings are fixed so that traces and the bench agree on values.
package io_port_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_PRESS = 2'd1,
        ST_READY      = 2'd2
    } io_state_e;

    localparam int DATA_W_DEF   = 32;
    localparam int SW_W_DEF     = 16;
    localparam int CNT_W_DEF    = 8;
    localparam int DEBOUNCE_DEF = 50000;

endpackage

// File: rtl/io_port_responder_if.sv
// Handshake bus between the control unit (master) and the I/O port responder (slave).
interface io_port_responder_if #(
    parameter int DATA_W = 32
) ();

    logic              in_req;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              new_out;
    logic [DATA_W-1:0] out_data;
    logic              wake_up;

    modport master (
        output in_req, new_out, out_data,
        input  in_ready, in_data, wake_up
    );

    modport slave (
        input  in_req, new_out, out_data,
        output in_ready, in_data, wake_up
    );

endinterface

// File: rtl/io_port_responder_debounce.sv
// Confirm-button conditioner: 2-flop synchronizer, stability counter, and a
// registered one-cycle pulse on each accepted rising edge.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronize the raw button and accept a new level only after it has held steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            press_r  <= 1'b0;
            cnt_r    <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == LIMIT) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
                press_r  <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign stable = stable_r;
    assign press  = press_r;

endmodule

// File: rtl/io_port_responder.sv
// Peripheral end of the core's I/O handshake: serves input requests from the
// switches on a debounced confirm press, captures output strobes, and wakes the core.
module io_port_responder
    import io_port_responder_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int SW_W            = SW_W_DEF,
    parameter int SIGN_EXT        = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_port_responder_if.slave   bus,
    input  logic [SW_W-1:0]      sw,
    input  logic                 btn_confirm,
    output logic [DATA_W-1:0]    out_reg,
    output logic [CNT_W-1:0]     out_count,
    output logic                 waiting_led
);

    io_state_e          state_r;
    logic               in_ready_r;
    logic               wake_up_r;
    logic               waiting_r;
    logic [DATA_W-1:0]  in_data_r;
    logic [DATA_W-1:0]  out_reg_r;
    logic [CNT_W-1:0]   out_count_r;
    logic               btn_stable_s;
    logic               btn_press_s;
    logic               press_s;

    function automatic logic [DATA_W-1:0] ext_sw(input logic [SW_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < SW_W) begin
                r[i] = v[i];
            end else begin
                r[i] = (SIGN_EXT != 0) ? v[SW_W-1] : 1'b0;
            end
        end
        return r;
    endfunction

    io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_confirm),
        .stable (btn_stable_s),
        .press  (btn_press_s)
    );

    // A press is only trusted while the filtered level agrees with it.
    assign press_s = btn_press_s & btn_stable_s;

    // Input handshake FSM with registered in_ready, waiting_led and wake_up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            wake_up_r  <= 1'b0;
            waiting_r  <= 1'b0;
            in_data_r  <= '0;
        end else begin
            wake_up_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    in_ready_r <= 1'b0;
                    if (bus.in_req) begin
                        // A press on this same edge is not taken as the input value.
                        state_r   <= ST_WAIT_PRESS;
                        waiting_r <= 1'b1;
                    end else begin
                        waiting_r <= 1'b0;
                        wake_up_r <= press_s;
                    end
                end
                ST_WAIT_PRESS: begin
                    if (!bus.in_req) begin
                        state_r   <= ST_IDLE;
                        waiting_r <= 1'b0;
                    end else if (press_s) begin
                        in_data_r  <= ext_sw(sw);
                        in_ready_r <= 1'b1;
                        waiting_r  <= 1'b0;
                        state_r    <= ST_READY;
                    end else begin
                        waiting_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    waiting_r <= 1'b0;
                    if (!bus.in_req) begin
                        in_ready_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    waiting_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output capture runs independently of the input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg_r   <= '0;
            out_count_r <= '0;
        end else if (bus.new_out) begin
            out_reg_r   <= bus.out_data;
            out_count_r <= out_count_r + CNT_W'(1);
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.in_data  = in_data_r;
    assign bus.wake_up  = wake_up_r;
    assign out_reg      = out_reg_r;
    assign out_count    = out_count_r;
    assign waiting_led  = waiting_r;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder with short debounce; a second instance checks zero-extension.
module tb_io_port_responder;

    localparam int DATA_W = 32;
    localparam int SW_W   = 16;
    localparam int CNT_W  = 8;
    localparam int DEB    = 4;

    logic              clk;
    logic              rst_n;
    logic              in_req;
    logic              new_out;
    logic [DATA_W-1:0] out_data;
    logic [SW_W-1:0]   sw;
    logic              btn;

    logic [DATA_W-1:0] out_reg0, out_reg1;
    logic [CNT_W-1:0]  out_count0, out_count1;
    logic              waiting0, waiting1;

    int total = 0;
    int bad   = 0;
    int wake_cnt;
    int wake_idx;
    int rdy_idx;
    int rdy_seen;

    io_port_responder_if #(.DATA_W(DATA_W)) bus0 ();
    io_port_responder_if #(.DATA_W(DATA_W)) bus1 ();

    assign bus0.in_req   = in_req;
    assign bus0.new_out  = new_out;
    assign bus0.out_data = out_data;
    assign bus1.in_req   = in_req;
    assign bus1.new_out  = new_out;
    assign bus1.out_data = out_data;

    io_port_responder #(
        .DATA_W(DATA_W), .SW_W(SW_W), .SIGN_EXT(1), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .sw(sw), .btn_confirm(btn),
        .out_reg(out_reg0), .out_count(out_count0), .waiting_led(waiting0)
    );

    io_port_responder #(
        .DATA_W(DATA_W), .SW_W(SW_W), .SIGN_EXT(0), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
    ) dut_zx (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .sw(sw), .btn_confirm(btn),
        .out_reg(out_reg1), .out_count(out_count1), .waiting_led(waiting1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_req = 1'b0; new_out = 1'b0; out_data = '0; sw = '0; btn = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", {31'd0, bus0.in_ready}, 32'd0);
        check("rst_wake", {31'd0, bus0.wake_up}, 32'd0);
        check("rst_waiting", {31'd0, waiting0}, 32'd0);
        check("rst_out_reg", out_reg0, 32'd0);
        check("rst_out_count", {24'd0, out_count0}, 32'd0);
        check("rst_in_data", bus0.in_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Three output strobes
        new_out = 1'b1; out_data = 32'h5; tick();
        check("out1_reg", out_reg0, 32'h5);
        check("out1_cnt", {24'd0, out_count0}, 32'd1);
        out_data = 32'hA; tick();
        out_data = 32'h7; tick();
        new_out = 1'b0;
        check("out3_reg", out_reg0, 32'h7);
        check("out3_cnt", {24'd0, out_count0}, 32'd3);
        tick();
        check("out_hold_cnt", {24'd0, out_count0}, 32'd3);

        // Input request with clean press: in_ready 7 edges after btn rises
        in_req = 1'b1; tick();
        check("req_waiting", {31'd0, waiting0}, 32'd1);
        sw = 16'hFFFE; btn = 1'b1;
        repeat (6) tick();
        check("rdy_not_yet", {31'd0, bus0.in_ready}, 32'd0);
        tick();
        check("rdy_at_7", {31'd0, bus0.in_ready}, 32'd1);
        check("in_data_sx", bus0.in_data, 32'hFFFFFFFE);
        check("in_data_zx", bus1.in_data, 32'h0000FFFE);
        check("rdy_waiting_off", {31'd0, waiting0}, 32'd0);

        // Drop in_req together with an output strobe
        btn = 1'b0; in_req = 1'b0; new_out = 1'b1; out_data = 32'h77;
        tick();
        new_out = 1'b0;
        check("drop_rdy", {31'd0, bus0.in_ready}, 32'd0);
        check("conc_out_reg", out_reg0, 32'h77);
        check("conc_out_cnt", {24'd0, out_count0}, 32'd4);
        check("in_data_kept", bus0.in_data, 32'hFFFFFFFE);
        repeat (8) tick();

        // Wake on press while idle: exactly one cycle, 7 edges after btn rises
        btn = 1'b1; wake_cnt = 0; wake_idx = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus0.wake_up === 1'b1) begin
                wake_cnt++;
                if (wake_idx == 0) wake_idx = i;
            end
        end
        check("wake_count", wake_cnt, 32'd1);
        check("wake_idx", wake_idx, 32'd7);
        btn = 1'b0;
        repeat (8) tick();

        // Bouncing button while waiting: no press
        in_req = 1'b1; tick();
        wake_cnt = 0; rdy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            tick();
            if (bus0.in_ready === 1'b1) rdy_seen++;
        end
        btn = 1'b0;
        repeat (10) begin
            tick();
            if (bus0.in_ready === 1'b1) rdy_seen++;
        end
        check("bounce_no_rdy", rdy_seen, 32'd0);
        check("bounce_waiting", {31'd0, waiting0}, 32'd1);

        // Press during WAIT_PRESS: ready but never wake
        sw = 16'h1234; btn = 1'b1; wake_cnt = 0; rdy_idx = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus0.wake_up === 1'b1) wake_cnt++;
            if (bus0.in_ready === 1'b1 && rdy_idx == 0) rdy_idx = i;
        end
        check("wait_no_wake", wake_cnt, 32'd0);
        check("wait_rdy_idx", rdy_idx, 32'd7);
        check("in_data_1234", bus0.in_data, 32'h00001234);
        check("in_data_1234_zx", bus1.in_data, 32'h00001234);
        in_req = 1'b0; btn = 1'b0; tick();
        check("drop_rdy2", {31'd0, bus0.in_ready}, 32'd0);
        repeat (8) tick();

        // Abort during WAIT_PRESS
        in_req = 1'b1; tick();
        sw = 16'h8000;
        repeat (3) tick();
        check("abort_waiting", {31'd0, waiting0}, 32'd1);
        in_req = 1'b0; tick();
        check("abort_idle", {31'd0, waiting0}, 32'd0);
        check("abort_rdy", {31'd0, bus0.in_ready}, 32'd0);
        check("abort_data", bus0.in_data, 32'h00001234);

        // Press and in_req rising on the same edge: no wake, press not consumed
        btn = 1'b1;
        repeat (6) tick();
        in_req = 1'b1; tick();
        check("same_waiting", {31'd0, waiting0}, 32'd1);
        check("same_no_wake", {31'd0, bus0.wake_up}, 32'd0);
        rdy_seen = 0; wake_cnt = 0;
        repeat (8) begin
            tick();
            if (bus0.in_ready === 1'b1) rdy_seen++;
            if (bus0.wake_up === 1'b1) wake_cnt++;
        end
        check("same_no_rdy", rdy_seen, 32'd0);
        check("same_no_wake2", wake_cnt, 32'd0);
        in_req = 1'b0; btn = 1'b0; tick();
        repeat (8) tick();

        // Counter wrap: 4 + 251 = 255, then one more wraps to 0
        new_out = 1'b1;
        for (int i = 0; i < 251; i++) begin
            out_data = i;
            tick();
        end
        new_out = 1'b0;
        check("cnt_255", {24'd0, out_count0}, 32'd255);
        new_out = 1'b1; out_data = 32'hDEAD; tick();
        new_out = 1'b0;
        check("cnt_wrap", {24'd0, out_count0}, 32'd0);
        check("wrap_reg", out_reg0, 32'hDEAD);

        // Async reset in the middle of READY
        in_req = 1'b1; tick();
        btn = 1'b1;
        repeat (7) tick();
        check("pre_rst_rdy", {31'd0, bus0.in_ready}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rdy", {31'd0, bus0.in_ready}, 32'd0);
        check("arst_out_reg", out_reg0, 32'd0);
        check("arst_out_cnt", {24'd0, out_count0}, 32'd0);
        check("arst_in_data", bus0.in_data, 32'd0);
        tick();
        in_req = 1'b0; btn = 1'b0; rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
